// File: rtl/otter_hzd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package  : otter_hzd_pkg                                             |
// | Purpose  : Shared constants and types for the OTTER decode-stage     |
// |            hazard logic and the destination-register scoreboard.     |
// | Contents : register-file geometry, RV32I opcode constants, counter   |
// |            type, and has_rd() for generating issue_we / dec_use_*.   |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package otter_hzd_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  // Default per-register counter width; 2 bits cover EX, MEM and WB.
  localparam int SB_CNT_W   = 2;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYS    = 7'b1110011;

  typedef logic [SB_CNT_W-1:0] sb_cnt_t;

  // True when an instruction with this opcode writes its rd field.
  // Branches and stores reuse the rd bit positions for immediates.
  function automatic logic has_rd(input logic [6:0] opcode);
    case (opcode)
      OP_RTYPE, OP_ITYPE, OP_LOAD, OP_LUI,
      OP_AUIPC, OP_JAL, OP_JALR, OP_SYS: has_rd = 1'b1;
      default:                           has_rd = 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_write_scoreboard_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface: reg_write_scoreboard_if                                   |
// | Purpose  : Bundles decode, issue, writeback and squash signals of    |
// |            the scoreboard together with its status outputs.          |
// | Modports : master - pipeline side (drives requests, sees status)     |
// |            slave  - scoreboard side                                  |
// | Signals  : dec_rs1/rs2, dec_use_rs1/rs2, issue_valid/we/rd,          |
// |            wb_valid/we/rd, kill_valid[NKILL], kill_rd[5*NKILL],      |
// |            stall, issue_accept, pending_mask[32], err_overflow,      |
// |            err_underflow                                             |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
interface reg_write_scoreboard_if #(
  parameter int NKILL = 2
);
  import otter_hzd_pkg::*;

  logic [REG_ADDR_W-1:0]       dec_rs1;
  logic [REG_ADDR_W-1:0]       dec_rs2;
  logic                        dec_use_rs1;
  logic                        dec_use_rs2;
  logic                        issue_valid;
  logic                        issue_we;
  logic [REG_ADDR_W-1:0]       issue_rd;
  logic                        wb_valid;
  logic                        wb_we;
  logic [REG_ADDR_W-1:0]       wb_rd;
  logic [NKILL-1:0]            kill_valid;
  logic [REG_ADDR_W*NKILL-1:0] kill_rd;
  logic                        stall;
  logic                        issue_accept;
  logic [NUM_REGS-1:0]         pending_mask;
  logic                        err_overflow;
  logic                        err_underflow;

  modport master (
    output dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2,
    output issue_valid, issue_we, issue_rd,
    output wb_valid, wb_we, wb_rd,
    output kill_valid, kill_rd,
    input  stall, issue_accept, pending_mask, err_overflow, err_underflow
  );

  modport slave (
    input  dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2,
    input  issue_valid, issue_we, issue_rd,
    input  wb_valid, wb_we, wb_rd,
    input  kill_valid, kill_rd,
    output stall, issue_accept, pending_mask, err_overflow, err_underflow
  );

endinterface
`default_nettype wire

// File: rtl/sb_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : sb_counter                                                |
// | Purpose  : One saturating up/down in-flight write counter. Applies   |
// |            +inc_i and -dec_count_i in the same edge, clamping at     |
// |            MAX_INFLIGHT (ovf_o) and at zero (unf_o).                 |
// | Ports    : clk, rst_n (sync, active low), inc_i, dec_count_i,        |
// |            count_o (current), count_d_o (next), ovf_o, unf_o         |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module sb_counter #(
  parameter int CNT_W        = 2,
  parameter int MAX_INFLIGHT = 3,
  parameter int DEC_W        = 2
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             inc_i,
  input  wire logic [DEC_W-1:0] dec_count_i,
  output logic      [CNT_W-1:0] count_o,
  output logic      [CNT_W-1:0] count_d_o,
  output logic                  ovf_o,
  output logic                  unf_o
);

  // Wide enough to hold count + 1 and the largest decrement without wrap.
  localparam int SUM_W = ((CNT_W > DEC_W) ? CNT_W : DEC_W) + 2;
  localparam logic [SUM_W-1:0] MAX_C = SUM_W'(MAX_INFLIGHT);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [SUM_W-1:0] tot;
  logic [SUM_W-1:0] res;

  // Adding the increment before subtracting lets a same-edge issue and
  // retire cancel cleanly, even when the counter sits at MAX_INFLIGHT.
  always_comb begin
    tot     = SUM_W'(count_q) + SUM_W'(inc_i);
    res     = '0;
    ovf_o   = 1'b0;
    unf_o   = 1'b0;
    count_d = count_q;
    if (tot < SUM_W'(dec_count_i)) begin
      count_d = '0;
      unf_o   = 1'b1;
    end else begin
      res = tot - SUM_W'(dec_count_i);
      if (res > MAX_C) begin
        count_d = CNT_W'(MAX_INFLIGHT);
        ovf_o   = 1'b1;
      end else begin
        count_d = res[CNT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count_o   = count_q;
  assign count_d_o = count_d;

endmodule
`default_nettype wire

// File: rtl/reg_write_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : reg_write_scoreboard                                      |
// | Purpose  : Tracks in-flight destination-register writes from issue   |
// |            until writeback or squash, and stalls decode when a used  |
// |            source register still has a pending write.                |
// | Ports    : clk   - rising-edge clock                                 |
// |            rst_n - synchronous active-low reset                      |
// |            sb    - reg_write_scoreboard_if.slave (decode, issue,     |
// |                    writeback, kill inputs; stall, issue_accept,      |
// |                    pending_mask, err_overflow, err_underflow)        |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module reg_write_scoreboard
  import otter_hzd_pkg::*;
#(
  parameter int MAX_INFLIGHT = 3,
  parameter int CNT_W        = 2,   // 2**CNT_W-1 must be >= MAX_INFLIGHT
  parameter int NKILL        = 2
) (
  input wire logic              clk,
  input wire logic              rst_n,
  reg_write_scoreboard_if.slave sb
);

  // Largest decrement in one edge is one writeback plus NKILL squashes.
  localparam int DEC_W = $clog2(NKILL + 2);

  logic [NUM_REGS-1:0] nz;         // count[r] != 0, current state
  logic [NUM_REGS-1:0] nz_d;       // count[r] != 0, next state
  logic [NUM_REGS-1:0] ovf_vec;
  logic [NUM_REGS-1:0] unf_vec;
  logic [NUM_REGS-1:0] pending_q;
  logic                err_ovf_q;
  logic                err_unf_q;
  logic                stall;
  logic                accept;

  // x0 is never tracked.
  assign nz[0]      = 1'b0;
  assign nz_d[0]    = 1'b0;
  assign ovf_vec[0] = 1'b0;
  assign unf_vec[0] = 1'b0;

  // A retiring write still stalls in its own cycle: the count only drops
  // at the edge where the regfile is written.
  assign stall  = (sb.dec_use_rs1 && (sb.dec_rs1 != '0) && nz[sb.dec_rs1]) ||
                  (sb.dec_use_rs2 && (sb.dec_rs2 != '0) && nz[sb.dec_rs2]);
  assign accept = sb.issue_valid && !stall;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
    logic             inc;
    logic [DEC_W-1:0] dec_cnt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;

    assign inc = accept && sb.issue_we && (sb.issue_rd == REG_ADDR_W'(r));

    always_comb begin
      dec_cnt = DEC_W'(sb.wb_valid && sb.wb_we && (sb.wb_rd == REG_ADDR_W'(r)));
      for (int k = 0; k < NKILL; k++) begin
        if (sb.kill_valid[k] &&
            (sb.kill_rd[k*REG_ADDR_W +: REG_ADDR_W] == REG_ADDR_W'(r))) begin
          dec_cnt = dec_cnt + 1'b1;
        end
      end
    end

    sb_counter #(
      .CNT_W        (CNT_W),
      .MAX_INFLIGHT (MAX_INFLIGHT),
      .DEC_W        (DEC_W)
    ) u_cnt (
      .clk         (clk),
      .rst_n       (rst_n),
      .inc_i       (inc),
      .dec_count_i (dec_cnt),
      .count_o     (cnt),
      .count_d_o   (cnt_d),
      .ovf_o       (ovf_vec[r]),
      .unf_o       (unf_vec[r])
    );

    assign nz[r]   = |cnt;
    assign nz_d[r] = |cnt_d;
  end

  // Registered from next-state counts so the mask lines up with the
  // counters on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q <= '0;
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
    end else begin
      pending_q <= nz_d;
      err_ovf_q <= err_ovf_q | (|ovf_vec);
      err_unf_q <= err_unf_q | (|unf_vec);
    end
  end

  assign sb.stall         = stall;
  assign sb.issue_accept  = accept;
  assign sb.pending_mask  = pending_q;
  assign sb.err_overflow  = err_ovf_q;
  assign sb.err_underflow = err_unf_q;

endmodule
`default_nettype wire

// File: doc/reg_write_scoreboard.md
Name: reg_write_scoreboard

Overview:
- Writer-side companion to the OTTER decode-stage hazard check.
- Records every in-flight destination-register write from issue (decode→execute) until writeback or squash.
- Presents a registered pending-write view plus a combinational stall for the instruction currently in decode.
- Replaces rd-vs-rs comparisons against a single execute IR, so hazards against EX, MEM and WB are all covered.

Parameters:
- MAX_INFLIGHT, 3, maximum outstanding writes to one register (EX, MEM, WB stages).
- CNT_W, 2, per-register counter width; must satisfy 2^CNT_W-1 >= MAX_INFLIGHT.
- NKILL, 2, number of squash ports usable in one cycle (branch flush of DE/EX).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- dec_rs1  in  5  decode rs1 field (IR[19:15])
- dec_rs2  in  5  decode rs2 field (IR[24:20])
- dec_use_rs1  in  1  decode instruction reads rs1
- dec_use_rs2  in  1  decode instruction reads rs2
- issue_valid  in  1  decode instruction advancing to execute this cycle
- issue_we  in  1  issuing instruction writes rd
- issue_rd  in  5  issuing rd (IR[11:7])
- wb_valid  in  1  writeback-stage instruction commits this cycle
- wb_we  in  1  committing instruction writes rd
- wb_rd  in  5  committing rd
- kill_valid  in  NKILL  per-slot squash of an already-issued, never-to-retire write
- kill_rd  in  5*NKILL  packed rd per kill slot (slot k = bits 5k+4:5k)
- stall  out  1  decode must hold: a used source has a pending write
- issue_accept  out  1  issue_valid & ~stall
- pending_mask  out  32  bit r = count[r] != 0 (bit 0 always 0)
- err_overflow  out  1  sticky: issue to a register already at MAX_INFLIGHT
- err_underflow  out  1  sticky: retire/kill to a register with count 0

Behaviour:
- State: 31 counters count[1..31], CNT_W bits each. x0 is never tracked; any issue, wb or kill with rd=0 is ignored.
- Reset (rst_n=0 at clk edge): all counts 0, pending_mask=0, err_overflow=0, err_underflow=0. stall=0 follows from the zero counts.
- Reset mid-operation discards all in-flight tracking. The pipeline is flushed by the same reset.
- stall is combinational: (dec_use_rs1 & dec_rs1!=0 & count[dec_rs1]!=0) | (dec_use_rs2 & dec_rs2!=0 & count[dec_rs2]!=0).
- A write retiring in cycle N still stalls in cycle N. The regfile writes at the edge and decode reads combinationally, so consumer release is cycle N+1.
- Per register r, each edge computes net = inc - dec:
  - inc = issue_accept & issue_we & issue_rd==r.
  - dec = (wb_valid & wb_we & wb_rd==r) + popcount over k of (kill_valid[k] & kill_rd[k]==r).
- Issue while stalled is not accepted and does not increment.
- Simultaneous inc and dec to the same r: count unchanged, no error.
- Overflow: count at MAX_INFLIGHT and net>0 → count holds at MAX_INFLIGHT, err_overflow set.
- Underflow: net<0 exceeds count → count clamps to 0, err_underflow set.
- Error flags clear only on reset.
- Kill and wb may target the same r in one cycle; the decrements sum (up to 1+NKILL).
- pending_mask is registered from next-state counts, so it is valid the same edge the counts update.
- Latency: issue at edge N → pending from cycle N+1. Retire at edge N → cleared from cycle N+1.

Decomposition:
- Package otter_hzd_pkg holds:
  - REG_ADDR_W=5 and NUM_REGS=32.
  - Opcode constants: OP_BRANCH=7'b1100011, OP_STORE=7'b0100011, OP_RTYPE=7'b0110011, OP_LUI, OP_AUIPC, OP_JAL.
  - typedef sb_cnt_t (logic [CNT_W-1:0]).
  - Helper function has_rd(opcode), for the decode stage to generate issue_we and dec_use_*.
- Sub-module sb_counter: one saturating up/down counter with inc, dec_count, ovf and unf outputs; generated 31 times.

Test Plan:
- Reset, then dec_rs1=5, dec_use_rs1=1 → stall=0, pending_mask=0, both error flags 0.
- Issue rd=5, next cycle dec_rs1=5 → stall=1, pending_mask[5]=1. wb rd=5 → stall stays 1 that cycle, 0 the cycle after.
- Issue rd=7 three consecutive times, then wb rd=7 twice → pending_mask[7] remains 1. Third wb clears it. A fourth issue before any wb sets err_overflow.
- Same cycle issue rd=9 and wb rd=9 with count[9]=1 → count stays 1, no error.
- Issue rd=0 and decode uses rs1=0 → no tracking, stall=0.
- Issue rd=3 and rd=4, then kill_valid=2'b11, kill_rd={4,3} → pending_mask[4:3]=0 next cycle. A wb rd=3 afterwards sets err_underflow. rst_n=0 mid-stream clears all state in one edge.
